// File: rtl/fp_alu_arb_pkg.sv
// Shared types and constants for the FP ALU round-robin arbiter.
package fp_alu_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  localparam logic [DATA_W-1:0] QNAN16 = 32'h00007E00;
  localparam logic [DATA_W-1:0] QNAN32 = 32'h7FC00000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module rr_arbiter
  import fp_alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int unsigned IDW = $clog2(NREQ);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_grant) + k) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Round-robin scheduler sharing one FP ALU among NREQ requesters, one op in flight.
// Optional WAIT watchdog enabled by defining FP_ARB_TIMEOUT_EN.
module fp_alu_arbiter
  import fp_alu_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_op_a,
  input  logic [NREQ-1:0][DATA_W-1:0]  req_op_b,
  input  logic [NREQ-1:0][1:0]         req_op_code,
  input  logic [NREQ-1:0]              req_mode_fp,
  output logic [DATA_W-1:0]            alu_op_a,
  output logic [DATA_W-1:0]            alu_op_b,
  output logic [1:0]                   alu_op_code,
  output logic                         alu_mode_fp,
  output logic                         alu_start,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic [FLAG_W-1:0]            alu_flags,
  input  logic                         alu_valid_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NREQ)-1:0]      rsp_id,
  output logic [DATA_W-1:0]            rsp_result,
  output logic [FLAG_W-1:0]            rsp_flags,
  output logic                         rsp_timeout
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] op_id_q;
  logic [IDW-1:0] grant_id;
  logic [NREQ-1:0] grant;
  logic           accept;
  logic           tmo_hit;
  logic           wait_done;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Offer only in IDLE, and never while reset is asserted.
  assign req_ready = (state_q == ST_IDLE && rst) ? grant : '0;
  assign accept    = |req_ready;
  assign wait_done = (state_q == ST_WAIT) && (alu_valid_out || tmo_hit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (alu_valid_out || tmo_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      op_id_q      <= '0;
      alu_op_a     <= '0;
      alu_op_b     <= '0;
      alu_op_code  <= '0;
      alu_mode_fp  <= 1'b0;
      alu_start    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
    end else begin
      state_q   <= state_d;
      alu_start <= accept;
      if (accept) begin
        alu_op_a     <= req_op_a[grant_id];
        alu_op_b     <= req_op_b[grant_id];
        alu_op_code  <= req_op_code[grant_id];
        alu_mode_fp  <= req_mode_fp[grant_id];
        op_id_q      <= grant_id;
        last_grant_q <= grant_id;
      end
      // A real completion wins over an expiring watchdog.
      if (wait_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id_q;
        if (alu_valid_out) begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
        end else begin
          rsp_result <= alu_mode_fp ? QNAN16 : QNAN32;
          rsp_flags  <= '0;
        end
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FP_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)     tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (wait_done) rsp_timeout <= !alu_valid_out;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
  assign rsp_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed self-checking bench for fp_alu_arbiter with a fixed-latency ALU model.
module tb_fp_alu_arbiter;

  localparam int unsigned NREQ = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][31:0]   req_op_a = '0;
  logic [NREQ-1:0][31:0]   req_op_b = '0;
  logic [NREQ-1:0][1:0]    req_op_code = '0;
  logic [NREQ-1:0]         req_mode_fp = '0;
  logic [31:0]             alu_op_a, alu_op_b;
  logic [1:0]              alu_op_code;
  logic                    alu_mode_fp, alu_start;
  logic [31:0]             alu_result;
  logic [4:0]              alu_flags;
  logic                    alu_valid_out = 1'b0;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b0;
  logic [1:0]              rsp_id;
  logic [31:0]             rsp_result;
  logic [4:0]              rsp_flags;
  logic                    rsp_timeout;

  int errors = 0;
  int checks = 0;

  // ALU model knobs
  int          alu_lat = 2;
  bit          alu_en  = 1'b1;
  int          alu_cnt = 0;
  int          start_cnt = 0;
  logic [31:0] alu_res = '0;
  logic [4:0]  alu_flg = '0;

  assign alu_result = alu_res;
  assign alu_flags  = alu_flg;

  always #5 clk = ~clk;

  fp_alu_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_op_code(req_op_code), .req_mode_fp(req_mode_fp),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp), .alu_start(alu_start),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_valid_out(alu_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout)
  );

  // valid_out pulses for one cycle, alu_lat cycles after start is seen.
  always @(posedge clk) begin
    if (alu_start) begin
      alu_cnt       <= alu_en ? alu_lat : 0;
      alu_valid_out <= 1'b0;
    end else if (alu_cnt == 1) begin
      alu_cnt       <= 0;
      alu_valid_out <= 1'b1;
    end else begin
      alu_valid_out <= 1'b0;
      if (alu_cnt > 1) alu_cnt <= alu_cnt - 1;
    end
  end

  always @(posedge clk) if (alu_start) start_cnt <= start_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    alu_en = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0;
    step();
    checks++;
    if ({alu_start, rsp_valid, rsp_timeout, req_ready, alu_op_a, rsp_result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b rsp_valid=%b tmo=%b req_ready=%b op_a=%h result=%h, required all 0",
               alu_start, rsp_valid, rsp_timeout, req_ready, alu_op_a, rsp_result);
    end
    rst = 1'b1;
    step();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL idle_no_req: req_ready=%b required 0000", req_ready);
    end
  endtask

  task automatic test_single_fp16();
    int base;
    do_reset();
    alu_lat = 2; alu_res = 32'h00004200; alu_flg = 5'b0;
    req_op_a[0] = 32'h00003C00; req_op_b[0] = 32'h00004000;
    req_op_code[0] = 2'b00; req_mode_fp[0] = 1'b1;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: req_ready=%b required 0001", req_ready);
    end
    base = start_cnt;
    step();                 // handshake edge T
    req_valid = '0;
    checks++;
    if (alu_start !== 1'b1 || alu_op_a !== 32'h00003C00 || alu_mode_fp !== 1'b1) begin
      errors++; $display("FAIL single_issue: start=%b op_a=%h mode=%b required 1 00003c00 1",
                         alu_start, alu_op_a, alu_mode_fp);
    end
    step();                 // T+1
    checks++;
    if (alu_start !== 1'b0 || start_cnt != base + 1) begin
      errors++; $display("FAIL single_pulse: start=%b pulses=%0d required 0 and 1 pulse",
                         alu_start, start_cnt - base);
    end
    step(); step();         // T+3
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: rsp_valid=%b at T+3 required 0", rsp_valid);
    end
    step();                 // T+4
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'h00004200) begin
      errors++; $display("FAIL single_rsp: valid=%b id=%0d result=%h required 1 0 00004200",
                         rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_drop: rsp_valid=%b after accept required 0", rsp_valid);
    end
  endtask

  task automatic test_fairness();
    int order[$];
    int g, cyc;
    do_reset();
    alu_lat = 1;
    for (int i = 0; i < NREQ; i++) begin
      req_op_a[i] = 32'h100 + i;
      req_mode_fp[i] = 1'b0;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    cyc = 0;
    #1;
    while (order.size() < 5 && cyc < 100) begin
      g = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      step();
      cyc++;
      if (g >= 0) begin
        order.push_back(g);
        checks++;
        if (alu_start !== 1'b1 || alu_op_a !== 32'h100 + g) begin
          errors++; $display("FAIL fair_issue: start=%b op_a=%h required 1 %h", alu_start, alu_op_a, 32'h100 + g);
        end
      end
    end
    req_valid = '0;
    checks++;
    if (order.size() != 5) begin
      errors++; $display("FAIL fair_count: grants=%0d required 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (order[k] != k % NREQ) begin
          errors++; $display("FAIL fair_order[%0d]: granted %0d required %0d", k, order[k], k % NREQ);
        end
      end
    end
    repeat (6) step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] held;
    do_reset();
    alu_lat = 2; alu_res = 32'h3F800000; alu_flg = 5'b00001;
    req_op_a[1] = 32'h11111111; req_op_a[2] = 32'h22222222;
    req_valid = 4'b0010;
    #1;
    step();
    req_valid = 4'b0100;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_busy_ready: req_ready=%b while busy required 0000", req_ready);
      end
      step(); n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      errors++; $display("FAIL bp_rsp: valid=%b id=%0d required 1 1", rsp_valid, rsp_id);
    end
    held = rsp_result;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== held || held !== 32'h3F800000 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b result=%h ready=%b required 1 3f800000 0000",
                           c, rsp_valid, rsp_result, req_ready);
      end
    end
    rsp_ready = 1'b1;
    step();                 // response handshake R
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_next_grant: valid=%b req_ready=%b required 0 0100", rsp_valid, req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (alu_start !== 1'b1 || alu_op_a !== 32'h22222222) begin
      errors++; $display("FAIL bp_issue2: start=%b op_a=%h required 1 22222222", alu_start, alu_op_a);
    end
    rsp_ready = 1'b1;
    repeat (8) step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_divzero();
    int n;
    do_reset();
    alu_lat = 3; alu_res = 32'h00007C00; alu_flg = 5'b01000;
    req_op_a[3] = 32'h00003C00; req_op_b[3] = 32'h00000000;
    req_op_code[3] = 2'b11; req_mode_fp[3] = 1'b1;
    req_valid = 4'b1000;
    #1;
    step();
    req_valid = '0;
    checks++;
    if (alu_start !== 1'b1 || alu_op_code !== 2'b11 || alu_op_b !== 32'h0) begin
      errors++; $display("FAIL div_issue: start=%b code=%b op_b=%h required 1 11 00000000",
                         alu_start, alu_op_code, alu_op_b);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin step(); n++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'h00007C00 || rsp_flags !== 5'b01000) begin
      errors++; $display("FAIL div_rsp: valid=%b id=%0d result=%h flags=%b required 1 3 00007c00 01000",
                         rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    alu_lat = 10; alu_res = 32'hDEADBEEF; alu_flg = 5'b10101;
    req_op_a[0] = 32'hAAAA0000; req_mode_fp[0] = 1'b0;
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = '0;
    step(); step();         // now in WAIT
    rst = 1'b0;
    #1;
    checks++;
    if ({alu_start, rsp_valid, rsp_timeout, req_ready, alu_op_a, alu_op_b, alu_op_code,
         alu_mode_fp, rsp_id, rsp_result, rsp_flags} !== '0) begin
      errors++; $display("FAIL midreset_outputs: start=%b rsp_valid=%b op_a=%h result=%h required all 0",
                         alu_start, rsp_valid, alu_op_a, rsp_result);
    end
    step();
    rst = 1'b1;
    step();
    alu_lat = 3; alu_res = 32'h12345678; alu_flg = 5'b0;
    req_op_a[1] = 32'hBBBB0000;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midreset_first: req_ready=%b required 0001", req_ready);
    end
    step();                 // handshake T
    req_valid = '0;
    step(); step(); step(); // T+3
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_stale: rsp_valid=%b at T+3 required 0", rsp_valid);
    end
    step(); step();         // T+5
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'h12345678) begin
      errors++; $display("FAIL midreset_rsp: valid=%b id=%0d result=%h required 1 0 12345678",
                         rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

`ifdef FP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    alu_en = 1'b0;
    req_op_a[0] = 32'h00003C00; req_mode_fp[0] = 1'b1;
    req_valid = 4'b0001;
    #1;
    step();                 // handshake T, WAIT entered at T+1
    req_valid = '0;
    repeat (8) step();      // T+8
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_early: rsp_valid=%b at T+8 required 0", rsp_valid);
    end
    step();                 // T+9 = WAIT entry + 8
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== 32'h00007E00 || rsp_flags !== 5'b0) begin
      errors++; $display("FAIL tmo_rsp: valid=%b tmo=%b result=%h flags=%b required 1 1 00007e00 00000",
                         rsp_valid, rsp_timeout, rsp_result, rsp_flags);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    alu_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_fp16();
    test_fairness();
    test_backpressure();
    test_divzero();
    test_reset_mid_op();
`ifdef FP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
